// File: rtl/coin_acceptor_if.sv
// Bus between the coin chutes, the coin acceptor and the vending FSM.
// coin_code protocol: a non-zero code is a one-cycle pulse per accepted coin.
// There is no back-pressure; the vending FSM must take the code in that cycle.
interface coin_if;
  logic       sense5;
  logic       sense10;
  logic [1:0] coin_code;
  logic       reject;
  logic       jam;
  logic       busy;
  logic [7:0] credit_total;

  // Sensor side drives sense lines and observes the results.
  modport master (
    output sense5, sense10,
    input  coin_code, reject, jam, busy, credit_total
  );

  // Acceptor side.
  modport slave (
    input  sense5, sense10,
    output coin_code, reject, jam, busy, credit_total
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes raw chute sensors, filters glitches, rejects
// ambiguous insertions, detects jams and keeps a saturating credit tally.
// All outputs are decoded from the state register or held in flops.
module coin_acceptor #(
  parameter int MIN_PULSE  = 3,
  parameter int MAX_PULSE  = 200,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  coin_if.slave      bus,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(MAX_PULSE + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_PULSE);
  localparam logic [CW-1:0] JAM_LAST = CW'(MAX_PULSE - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEASURE = 3'd1,
    EMIT    = 3'd2,
    REJECT  = 3'd3,
    GAP     = 3'd4,
    JAM     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync5_q, sync10_q;
  logic [CW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          ten_q, ten_d;
  // Cleared by reset so a coin already in the chute at reset release is
  // never counted: IDLE only starts coins once a full quiet gap was seen.
  logic          armed_q, armed_d;
  logic [7:0]    credit_q, credit_d;

  logic          s5, s10, both_low, gap_done, lat_s, oth_s;
  logic [GW-1:0] gap_next;
  logic [8:0]    credit_sum;

  assign s5       = sync5_q[1];
  assign s10      = sync10_q[1];
  assign both_low = !s5 && !s10;
  assign gap_done = both_low && (gap_cnt_q == GAP_LAST);
  assign gap_next = both_low ? gap_cnt_q + GW'(1) : '0;
  assign lat_s    = ten_q ? s10 : s5;
  assign oth_s    = ten_q ? s5 : s10;
  assign credit_sum = {1'b0, credit_q} + (ten_q ? 9'd2 : 9'd1);

  // Synchronizers, state register and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync5_q     <= '0;
      sync10_q    <= '0;
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      gap_cnt_q   <= '0;
      ten_q       <= 1'b0;
      armed_q     <= 1'b0;
      credit_q    <= '0;
    end else begin
      sync5_q     <= {sync5_q[0], bus.sense5};
      sync10_q    <= {sync10_q[0], bus.sense10};
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ten_q       <= ten_d;
      armed_q     <= armed_d;
      credit_q    <= credit_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ten_d       = ten_q;
    armed_d     = armed_q;
    credit_d    = credit_q;
    case (state_q)
      IDLE: begin
        if (!armed_q) begin
          gap_cnt_d = gap_next;
          if (gap_done) begin
            armed_d   = 1'b1;
            gap_cnt_d = '0;
          end
        end else if (s5 && s10) begin
          state_d = REJECT;
        end else if (s5 || s10) begin
          state_d     = MEASURE;
          ten_d       = s10;
          pulse_cnt_d = CW'(1);
        end
      end
      MEASURE: begin
        if (oth_s) begin
          state_d = REJECT;
        end else if (lat_s) begin
          if (pulse_cnt_q == JAM_LAST) begin
            state_d   = JAM;
            gap_cnt_d = '0;
          end else begin
            pulse_cnt_d = pulse_cnt_q + CW'(1);
          end
        end else if (pulse_cnt_q >= MIN_C) begin
          state_d = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        credit_d  = credit_sum[8] ? 8'hFF : credit_sum[7:0];
        state_d   = GAP;
        gap_cnt_d = '0;
      end
      REJECT: begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end
      GAP, JAM: begin
        gap_cnt_d = gap_next;
        if (gap_done) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.coin_code    = (state_q == EMIT) ? (ten_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.reject       = (state_q == REJECT);
  assign bus.jam          = (state_q == JAM);
  assign bus.busy         = (state_q != IDLE);
  assign bus.credit_total = credit_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with hand-computed expectations.
module tb_coin_acceptor;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;
  coin_if     bus ();

  coin_acceptor dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  int vectors     = 0;
  int miscompares = 0;
  int n5 = 0, n10 = 0, nrej = 0, nbad = 0;

  // Pulse monitor: counts cycles each output pulse is high.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.coin_code == 2'b01) n5++;
      if (bus.coin_code == 2'b10) n10++;
      if (bus.coin_code == 2'b11) nbad++;
      if (bus.reject) nrej++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (!bus.busy) break;
      tick();
    end
    check(tag, {31'b0, bus.busy}, 32'd0);
  endtask

  // Drives one coin of the given width; ends 4 ticks after the fall.
  task automatic send_coin(input bit is10, input int width, input bit ok, input string tag);
    logic [1:0] exp_code;
    exp_code = ok ? (is10 ? 2'b10 : 2'b01) : 2'b00;
    if (is10) bus.sense10 = 1'b1; else bus.sense5 = 1'b1;
    repeat (width) tick();
    bus.sense5  = 1'b0;
    bus.sense10 = 1'b0;
    tick();
    tick();
    check({tag, "_early"}, {30'b0, bus.coin_code}, 32'd0);
    tick();
    check({tag, "_code"}, {30'b0, bus.coin_code}, {30'b0, exp_code});
    tick();
    check({tag, "_after"}, {30'b0, bus.coin_code}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (8) tick();
  endtask

  int s5c, s10c, src;

  initial begin
    reset = 1'b0;
    bus.sense5  = 1'b0;
    bus.sense10 = 1'b0;
    repeat (3) tick();
    check("rst_code",   {30'b0, bus.coin_code}, 32'd0);
    check("rst_busy",   {31'b0, bus.busy}, 32'd0);
    check("rst_jam",    {31'b0, bus.jam}, 32'd0);
    check("rst_reject", {31'b0, bus.reject}, 32'd0);
    check("rst_credit", {24'b0, bus.credit_total}, 32'd0);
    reset = 1'b1;
    repeat (8) tick();

    // Single 5-dollar coin with exact latency and busy release.
    send_coin(1'b0, 10, 1'b1, "c5");
    check("c5_credit", {24'b0, bus.credit_total}, 32'd1);
    repeat (3) tick();
    check("c5_busy_hold", {31'b0, bus.busy}, 32'd1);
    tick();
    check("c5_busy_fall", {31'b0, bus.busy}, 32'd0);
    tick();

    // Glitch of 2 cycles is dropped, 3 cycles is accepted.
    s10c = n10; src = nrej;
    send_coin(1'b1, 2, 1'b0, "glitch");
    wait_idle("glitch_idle");
    check("glitch_n10", n10 - s10c, 32'd0);
    check("glitch_rej", nrej - src, 32'd0);
    check("glitch_credit", {24'b0, bus.credit_total}, 32'd1);
    tick();
    send_coin(1'b1, 3, 1'b1, "c10min");
    wait_idle("c10min_idle");
    check("c10min_credit", {24'b0, bus.credit_total}, 32'd3);
    check("c10min_n10", n10 - s10c, 32'd1);

    // Ambiguous: second sensor joins mid-coin, then both together.
    s5c = n5; s10c = n10; src = nrej;
    bus.sense5 = 1'b1;
    repeat (4) tick();
    bus.sense10 = 1'b1;
    repeat (4) tick();
    bus.sense5 = 1'b0; bus.sense10 = 1'b0;
    wait_idle("amb1_idle");
    check("amb1_rej", nrej - src, 32'd1);
    bus.sense5 = 1'b1; bus.sense10 = 1'b1;
    repeat (5) tick();
    bus.sense5 = 1'b0; bus.sense10 = 1'b0;
    tick();
    wait_idle("amb2_idle");
    check("amb2_rej", nrej - src, 32'd2);
    check("amb_codes", (n5 - s5c) + (n10 - s10c), 32'd0);
    check("amb_credit", {24'b0, bus.credit_total}, 32'd3);

    // Jam: hold the 5-dollar chute for 250 cycles.
    s5c = n5;
    bus.sense5 = 1'b1;
    for (int i = 1; i <= 250; i++) begin
      tick();
      if (i == 150) check("jam_early", {31'b0, bus.jam}, 32'd0);
      if (i == 210) check("jam_set", {31'b0, bus.jam}, 32'd1);
    end
    check("jam_hold", {31'b0, bus.jam}, 32'd1);
    bus.sense5 = 1'b0;
    tick(); tick();
    check("jam_still", {31'b0, bus.jam}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (!bus.jam) break;
      tick();
    end
    check("jam_clear", {31'b0, bus.jam}, 32'd0);
    check("jam_no_code", n5 - s5c, 32'd0);
    tick();
    send_coin(1'b0, 6, 1'b1, "post_jam");
    wait_idle("post_jam_idle");
    check("post_jam_credit", {24'b0, bus.credit_total}, 32'd4);

    // Saturation: preload 254, then +2 and +1 clamp at 255.
    do_reset();
    for (int i = 0; i < 127; i++) begin
      send_coin(1'b1, 3, 1'b1, "preload");
      wait_idle("preload_idle");
    end
    check("preload_credit", {24'b0, bus.credit_total}, 32'd254);
    send_coin(1'b1, 4, 1'b1, "sat10");
    wait_idle("sat10_idle");
    check("sat10_credit", {24'b0, bus.credit_total}, 32'd255);
    send_coin(1'b0, 4, 1'b1, "sat5");
    wait_idle("sat5_idle");
    check("sat5_credit", {24'b0, bus.credit_total}, 32'd255);

    // Second coin starting 2 cycles after the first falls is merged away.
    s5c = n5;
    bus.sense5 = 1'b1;
    repeat (5) tick();
    bus.sense5 = 1'b0;
    tick(); tick();
    bus.sense5 = 1'b1;
    tick();
    check("merge_first", {30'b0, bus.coin_code}, 32'd1);
    repeat (6) tick();
    bus.sense5 = 1'b0;
    tick();
    wait_idle("merge_idle");
    check("merge_count", n5 - s5c, 32'd1);

    // Async reset in the middle of a coin, off the clock edge.
    s5c = n5;
    bus.sense5 = 1'b1;
    repeat (5) tick();
    #3;
    reset = 1'b0;
    #1;
    check("arst_code",   {30'b0, bus.coin_code}, 32'd0);
    check("arst_busy",   {31'b0, bus.busy}, 32'd0);
    check("arst_jam",    {31'b0, bus.jam}, 32'd0);
    check("arst_reject", {31'b0, bus.reject}, 32'd0);
    check("arst_credit", {24'b0, bus.credit_total}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();
    bus.sense5 = 1'b0;
    repeat (12) tick();
    check("arst_no_coin", n5 - s5c, 32'd0);
    check("arst_idle", {31'b0, bus.busy}, 32'd0);
    send_coin(1'b0, 5, 1'b1, "fresh");
    wait_idle("fresh_idle");
    check("fresh_credit", {24'b0, bus.credit_total}, 32'd1);
    check("never_11", nbad, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
